nibble_serial_adder_ctrl: RTL and testbench

- Sequencer that computes a WIDTH-bit sum by time-sharing a single `ripple_fulladder_4` instance, one nibble per clock, LSB nibble first.
- The carry is registered between nibbles.
- Gives the team a wide adder at the area cost of one 4-bit adder plus registers.
- Start/busy/done handshake toward the requesting logic.

---
 rtl/nibble_serial_adder_ctrl.sv | 145 ++++++++++++++
 tb/tb_nibble_serial_adder_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: WIDTH-bit adder built from one shared 4-bit adder.
// It processes one nibble per clock, LSB first, and registers the carry between nibbles.
// Ports: clk, rst (sync, active-high), start/a/b/cin (request, accepted when not busy),
//        busy/done (decoded from state), sum/co (result registers).
// Optional build macro NIBBLE_SERIAL_ADDER_SUB_EN adds the sub input (a - b).

module ripple_fulladder_4 (
  input  logic [3:0] a_i,
  input  logic [3:0] b_i,
  input  logic       ci_i,
  output logic [3:0] s_o,
  output logic       co_o
);
  logic [4:0] cy;

  assign cy[0] = ci_i;

  for (genvar i = 0; i < 4; i++) begin : g_fa
    assign s_o[i]  = a_i[i] ^ b_i[i] ^ cy[i];
    assign cy[i+1] = (a_i[i] & b_i[i]) |
                     (cy[i] & (a_i[i] ^ b_i[i]));
  end

  assign co_o = cy[4];
endmodule

module nibble_serial_adder_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             co
);
  localparam int NIB = WIDTH / 4;
  localparam int IW  = (NIB > 1) ? $clog2(NIB) : 1;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    idx_q, idx_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;

  logic [3:0]       nib_a, nib_b, nib_s;
  logic             nib_co;
  logic [WIDTH-1:0] b_ld;
  logic             c_ld;
  logic             last;

  // Subtraction is a + ~b + 1, so only the loaded operand and carry change.
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
  assign b_ld = sub ? ~b : b;
  assign c_ld = sub ? 1'b1 : cin;
`else
  assign b_ld = b;
  assign c_ld = cin;
`endif

  assign nib_a = a_q[{idx_q, 2'b00} +: 4];
  assign nib_b = b_q[{idx_q, 2'b00} +: 4];
  assign last  = (idx_q == IW'(NIB - 1));

  ripple_fulladder_4 u_fa4 (
    .a_i  (nib_a),
    .b_i  (nib_b),
    .ci_i (c_q),
    .s_o  (nib_s),
    .co_o (nib_co)
  );

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    c_d     = c_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    co_d    = co_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b_ld;
          c_d     = c_ld;
          idx_d   = '0;
          state_d = RUN;
        end else begin
          state_d = IDLE;
        end
      end
      RUN: begin
        sum_d[{idx_q, 2'b00} +: 4] = nib_s;
        c_d   = nib_co;
        idx_d = idx_q + IW'(1);
        if (last) begin
          co_d    = nib_co;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      c_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      co_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      c_q     <= c_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
    end
  end

  assign busy = (state_q == RUN);
  assign done = (state_q == DONE);
  assign sum  = sum_q;
  assign co   = co_q;
endmodule

// File: tb/tb_nibble_serial_adder_ctrl.sv
// tb_nibble_serial_adder_ctrl: directed test of the nibble-serial adder.
// WIDTH=16; sub-mode vectors only when NIBBLE_SERIAL_ADDER_SUB_EN is defined.

module tb_nibble_serial_adder_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        sub;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        busy;
  logic        done;
  logic [15:0] sum;
  logic        co;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_serial_adder_ctrl #(.WIDTH(16)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    .sub   (sub),
`endif
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .co    (co)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] av,
                       input logic [15:0] bv,
                       input logic cv,
                       input logic sv);
    a     = av;
    b     = bv;
    cin   = cv;
    sub   = sv;
    start = 1'b1;
  endtask

  // Accept at the next edge, expect 4 busy cycles, then a done pulse.
  task automatic run_op(input string tag,
                        input logic [15:0] av,
                        input logic [15:0] bv,
                        input logic cv,
                        input logic sv,
                        input logic [15:0] es,
                        input logic ec);
    drive(av, bv, cv, sv);
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk({tag, "_busy"}, 32'(busy), 32'd1);
      chk({tag, "_nodone"}, 32'(done), 32'd0);
      step();
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_dbusy"}, 32'(busy), 32'd0);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_co"}, 32'(co), 32'(ec));
    step();
    chk({tag, "_pulse"}, 32'(done), 32'd0);
    chk({tag, "_idle"}, 32'(busy), 32'd0);
    chk({tag, "_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    sub   = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    step();
    step();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_co", 32'(co), 32'd0);
    rst = 1'b0;
    step();
    chk("idle_busy", 32'(busy), 32'd0);

    run_op("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0);
    run_op("rip1", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1);
    run_op("rip2", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1);
    run_op("mix1", 16'h00FF, 16'h0F01, 1'b1, 1'b0, 16'h1001, 1'b0);
    run_op("mix2", 16'h8765, 16'h9876, 1'b0, 1'b0, 16'h1FDB, 1'b1);

    // start raised mid-RUN must be ignored
    drive(16'h0001, 16'h0001, 1'b0, 1'b0);
    step();
    a = 16'hAAAA;
    b = 16'h1111;
    step();
    chk("ign_busy1", 32'(busy), 32'd1);
    step();
    chk("ign_busy2", 32'(busy), 32'd1);
    start = 1'b0;
    step();
    chk("ign_busy3", 32'(busy), 32'd1);
    step();
    chk("ign_done", 32'(done), 32'd1);
    chk("ign_sum", 32'(sum), 32'h0002);
    chk("ign_co", 32'(co), 32'd0);
    step();
    chk("ign_idle_b", 32'(busy), 32'd0);
    chk("ign_idle_d", 32'(done), 32'd0);
    step();
    chk("ign_idle_b2", 32'(busy), 32'd0);

    // back-to-back: second start presented in the DONE cycle
    drive(16'h000F, 16'h0001, 1'b0, 1'b0);
    step();
    for (int i = 0; i < 4; i++) begin
      chk("b2b_busy1", 32'(busy), 32'd1);
      step();
    end
    chk("b2b_done1", 32'(done), 32'd1);
    chk("b2b_sum1", 32'(sum), 32'h0010);
    chk("b2b_co1", 32'(co), 32'd0);
    a = 16'h8000;
    b = 16'h8000;
    step();
    start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b2b_busy2", 32'(busy), 32'd1);
      chk("b2b_gap", 32'(done), 32'd0);
      step();
    end
    chk("b2b_done2", 32'(done), 32'd1);
    chk("b2b_sum2", 32'(sum), 32'h0000);
    chk("b2b_co2", 32'(co), 32'd1);
    step();
    chk("b2b_idle", 32'(done), 32'd0);

    // reset asserted during the second RUN cycle
    drive(16'h1234, 16'h1111, 1'b0, 1'b0);
    step();
    start = 1'b0;
    step();
    chk("mrst_run", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_done", 32'(done), 32'd0);
    chk("mrst_sum", 32'(sum), 32'd0);
    chk("mrst_co", 32'(co), 32'd0);
    for (int i = 0; i < 6; i++) begin
      step();
      chk("mrst_nodone", 32'(done), 32'd0);
      chk("mrst_nobusy", 32'(busy), 32'd0);
    end

    run_op("post", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0);

`ifdef NIBBLE_SERIAL_ADDER_SUB_EN
    run_op("sub1", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0);
    run_op("sub2", 16'h0007, 16'h0005, 1'b0, 1'b1, 16'h0002, 1'b1);
    run_op("sub0", 16'h0007, 16'h0005, 1'b1, 1'b0, 16'h000D, 1'b0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
